// File: rtl/e203_itcm_icb_arbt_pkg.sv
// Shared types and default sizing for the ITCM ICB arbiter slice.
// Optional build macro: E203_ITCM_ARBT_RR_EN (round-robin instead of fixed priority).
package e203_itcm_icb_arbt_pkg;

  localparam int ITCM_ADDR_WIDTH   = 16;
  localparam int ITCM_DATA_WIDTH   = 64;
  localparam int ARBT_OUTS_DEPTH   = 2;
  localparam int ARBT_STARVE_LIMIT = 4;

  // Source tag carried through the outstanding FIFO.
  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_id_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/e203_itcm_icb_arbt_if.sv
// Single-beat ICB channel: command and response halves with master/slave views.
interface e203_itcm_icb_arbt_if
  import e203_itcm_icb_arbt_pkg::*;
#(
  parameter int AW = ITCM_ADDR_WIDTH,
  parameter int DW = ITCM_DATA_WIDTH
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/e203_itcm_arbt_outs_fifo.sv
// Outstanding-command FIFO: remembers which requester owns each pending ITCM response.
module e203_itcm_arbt_outs_fifo
  import e203_itcm_icb_arbt_pkg::*;
#(
  parameter int DEPTH = ARBT_OUTS_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  src_id_e push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output src_id_e head
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  src_id_e       mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: state is updated with <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only read while count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/e203_itcm_icb_arbt.sv
// Shares the ITCM ICB port between IFU fetch and LSU; responses return in issue order.
// Build macro E203_ITCM_ARBT_RR_EN selects round-robin, otherwise IFU priority with LSU starvation override.
module e203_itcm_icb_arbt
  import e203_itcm_icb_arbt_pkg::*;
#(
  parameter int AW           = ITCM_ADDR_WIDTH,
  parameter int DW           = ITCM_DATA_WIDTH,
  parameter int OUTS_DEPTH   = ARBT_OUTS_DEPTH,
  parameter int STARVE_LIMIT = ARBT_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  e203_itcm_icb_arbt_if.slave  ifu,
  e203_itcm_icb_arbt_if.slave  lsu,
  e203_itcm_icb_arbt_if.master itcm,
  output logic                 arbt_orphan_rsp
);

  logic            fifo_full;
  logic            fifo_empty;
  src_id_e         head_id;
  src_id_e         push_id;
  logic            grant_lsu;
  logic            cmd_open;
  logic            cmd_hs;
  logic            rsp_open;
  logic            rsp_hs;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;

`ifdef E203_ITCM_ARBT_RR_EN
  src_id_e rr_ptr;

  assign grant_lsu = lsu.cmd_valid & (~ifu.cmd_valid | (rr_ptr == SRC_LSU));

  // After each accepted command the other requester gets the tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= SRC_IFU;
    else if (cmd_hs) rr_ptr <= grant_lsu ? SRC_IFU : SRC_LSU;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       lsu_hs;

  assign starve_hit = (starve_cnt == LIMIT);
  assign grant_lsu  = lsu.cmd_valid & (~ifu.cmd_valid | starve_hit);
  assign lsu_hs     = lsu.cmd_valid & lsu.cmd_ready;

  // Counts consecutive cycles the LSU waits; a dropped request restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lsu.cmd_valid && !lsu_hs) begin
      if (!starve_hit) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  // A full FIFO blocks new commands even if a response pops this cycle, so ready never depends on rsp_ready.
  assign cmd_open       = ~rst & ~fifo_full;
  assign itcm.cmd_valid = (ifu.cmd_valid | lsu.cmd_valid) & cmd_open;
  assign ifu.cmd_ready  = ifu.cmd_valid & ~grant_lsu & itcm.cmd_ready & cmd_open;
  assign lsu.cmd_ready  = grant_lsu & itcm.cmd_ready & cmd_open;
  assign cmd_hs         = itcm.cmd_valid & itcm.cmd_ready;
  assign push_id        = grant_lsu ? SRC_LSU : SRC_IFU;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cmd_addr  = ifu.cmd_addr;
    cmd_read  = 1'b1;
    cmd_wdata = '0;
    cmd_wmask = '0;
    if (grant_lsu) begin
      cmd_addr  = lsu.cmd_addr;
      cmd_read  = lsu.cmd_read;
      cmd_wdata = lsu.cmd_wdata;
      cmd_wmask = lsu.cmd_wmask;
    end
  end

  assign itcm.cmd_addr  = cmd_addr;
  assign itcm.cmd_read  = cmd_read;
  assign itcm.cmd_wdata = cmd_wdata;
  assign itcm.cmd_wmask = cmd_wmask;

  // With nothing outstanding a response is orphaned: accept and discard it.
  assign rsp_open       = itcm.rsp_valid & ~fifo_empty & ~rst;
  assign ifu.rsp_valid  = rsp_open & (head_id == SRC_IFU);
  assign lsu.rsp_valid  = rsp_open & (head_id == SRC_LSU);
  assign itcm.rsp_ready = ~rst & (fifo_empty |
                                  ((head_id == SRC_LSU) ? lsu.rsp_ready : ifu.rsp_ready));
  assign rsp_hs         = itcm.rsp_valid & itcm.rsp_ready;

  assign ifu.rsp_rdata = itcm.rsp_rdata;
  assign ifu.rsp_err   = itcm.rsp_err;
  assign lsu.rsp_rdata = itcm.rsp_rdata;
  assign lsu.rsp_err   = itcm.rsp_err;

  e203_itcm_arbt_outs_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_outs_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_hs),
    .push_id (push_id),
    .pop     (rsp_hs & ~fifo_empty),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   arbt_orphan_rsp <= 1'b0;
    else if (itcm.rsp_valid && fifo_empty)     arbt_orphan_rsp <= 1'b1;
  end

endmodule

// File: tb/tb_e203_itcm_icb_arbt.sv
// Self-checking bench for e203_itcm_icb_arbt (default build: fixed priority, depth 2, starve limit 4).
module tb_e203_itcm_icb_arbt;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  logic orphan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_itcm_icb_arbt_if #(.AW(16), .DW(64)) ifu_if ();
  e203_itcm_icb_arbt_if #(.AW(16), .DW(64)) lsu_if ();
  e203_itcm_icb_arbt_if #(.AW(16), .DW(64)) itcm_if ();

  e203_itcm_icb_arbt #(
    .AW(16), .DW(64), .OUTS_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu             (ifu_if),
    .lsu             (lsu_if),
    .itcm            (itcm_if),
    .arbt_orphan_rsp (orphan)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ia, input logic lv,
                       input logic [15:0] la, input logic lrd, input logic [63:0] lwd,
                       input logic [7:0] lwm, input logic cr, input logic rv,
                       input logic irr, input logic lrr, input logic [63:0] rdata,
                       input logic err);
    ifu_if.cmd_valid  = iv;
    ifu_if.cmd_addr   = ia;
    ifu_if.cmd_read   = 1'b1;
    ifu_if.cmd_wdata  = '0;
    ifu_if.cmd_wmask  = '0;
    ifu_if.rsp_ready  = irr;
    lsu_if.cmd_valid  = lv;
    lsu_if.cmd_addr   = la;
    lsu_if.cmd_read   = lrd;
    lsu_if.cmd_wdata  = lwd;
    lsu_if.cmd_wmask  = lwm;
    lsu_if.rsp_ready  = lrr;
    itcm_if.cmd_ready = cr;
    itcm_if.rsp_valid = rv;
    itcm_if.rsp_rdata = rdata;
    itcm_if.rsp_err   = err;
  endtask

  // Reference model: queue of owners of pending responses plus an LSU wait counter.
  bit m_q[$];
  int m_starve;
  bit m_orphan;
  bit e_cv, e_ir, e_lr, e_irv, e_lrv, e_rr, e_lwin, e_empty;

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_orphan = 0;
  endtask

  task automatic model_eval();
    bit full;
    full    = (m_q.size() >= DEPTH);
    e_empty = (m_q.size() == 0);
    e_lwin  = lsu_if.cmd_valid && (!ifu_if.cmd_valid || m_starve == LIMIT);
    e_cv    = (ifu_if.cmd_valid || lsu_if.cmd_valid) && !full;
    e_ir    = ifu_if.cmd_valid && !e_lwin && itcm_if.cmd_ready && !full;
    e_lr    = e_lwin && itcm_if.cmd_ready && !full;
    e_irv   = itcm_if.rsp_valid && !e_empty && (m_q[0] == 1'b0);
    e_lrv   = itcm_if.rsp_valid && !e_empty && (m_q[0] == 1'b1);
    e_rr    = e_empty ? 1'b1 : (m_q[0] ? lsu_if.rsp_ready : ifu_if.rsp_ready);
  endtask

  task automatic model_update();
    if (itcm_if.rsp_valid && e_rr && !e_empty) void'(m_q.pop_front());
    if (itcm_if.rsp_valid && e_empty) m_orphan = 1;
    if (e_cv && itcm_if.cmd_ready) m_q.push_back(e_lwin);
    if (lsu_if.cmd_valid && !e_lr) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else m_starve = 0;
  endtask

  task automatic model_checks();
    check("cmd_valid", itcm_if.cmd_valid, e_cv);
    check("ifu_cmd_ready", ifu_if.cmd_ready, e_ir);
    check("lsu_cmd_ready", lsu_if.cmd_ready, e_lr);
    check("ifu_rsp_valid", ifu_if.rsp_valid, e_irv);
    check("lsu_rsp_valid", lsu_if.rsp_valid, e_lrv);
    check("itcm_rsp_ready", itcm_if.rsp_ready, e_rr);
    check("ifu_rsp_rdata", ifu_if.rsp_rdata, itcm_if.rsp_rdata);
    check("lsu_rsp_err", lsu_if.rsp_err, itcm_if.rsp_err);
    check("orphan_flag", orphan, m_orphan);
    if (e_cv) begin
      check("cmd_addr", itcm_if.cmd_addr, e_lwin ? lsu_if.cmd_addr : ifu_if.cmd_addr);
      check("cmd_read", itcm_if.cmd_read, e_lwin ? lsu_if.cmd_read : 1'b1);
      check("cmd_wdata", itcm_if.cmd_wdata, e_lwin ? lsu_if.cmd_wdata : 64'h0);
      check("cmd_wmask", itcm_if.cmd_wmask, e_lwin ? lsu_if.cmd_wmask : 8'h0);
    end
  endtask

  // Called #1 after a negedge drive; returns at the next negedge.
  task automatic tick(input bit chk);
    model_eval();
    if (chk) model_checks();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;  logic [15:0] ia;
    logic        lv;  logic [15:0] la;
    logic        lrd; logic cr; logic rv; logic irr; logic lrr;
    logic [63:0] rdata;
    logic        cv;  logic [15:0] caddr; logic crd;
    logic        ir;  logic lr; logic irv; logic lrv; logic rr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // iv ia lv la lrd cr rv irr lrr rdata | cv caddr crd ir lr irv lrv rr
    tbl[0]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 16'h10, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b1, 16'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 16'h20, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b1, 16'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 16'h28, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b1, 16'h28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 16'h30, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'h30, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h6,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16'h30, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b1, 16'h30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h9,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 16'h00, 1'b1, 16'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,
                1'b1, 16'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'hB,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'h00, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hC,
                1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state with every input asserted.
    rst = 1'b1;
    model_reset();
    drive(1, 16'h10, 1, 16'h40, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'h0, 0);
    @(negedge clk);
    #1;
    check("rst itcm_cmd_valid", itcm_if.cmd_valid, 1'b0);
    check("rst ifu_cmd_ready", ifu_if.cmd_ready, 1'b0);
    check("rst lsu_cmd_ready", lsu_if.cmd_ready, 1'b0);
    check("rst ifu_rsp_valid", ifu_if.rsp_valid, 1'b0);
    check("rst lsu_rsp_valid", lsu_if.rsp_valid, 1'b0);
    check("rst itcm_rsp_ready", itcm_if.rsp_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: single IFU fetch, depth backpressure, LSU response stall.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].lv, tbl[i].la, tbl[i].lrd, 64'h0, 8'h0,
            tbl[i].cr, tbl[i].rv, tbl[i].irr, tbl[i].lrr, tbl[i].rdata, 1'b0);
      #1;
      check($sformatf("tbl%0d cmd_valid", i), itcm_if.cmd_valid, tbl[i].cv);
      if (tbl[i].cv) begin
        check($sformatf("tbl%0d cmd_addr", i), itcm_if.cmd_addr, tbl[i].caddr);
        check($sformatf("tbl%0d cmd_read", i), itcm_if.cmd_read, tbl[i].crd);
      end
      check($sformatf("tbl%0d ifu_cmd_ready", i), ifu_if.cmd_ready, tbl[i].ir);
      check($sformatf("tbl%0d lsu_cmd_ready", i), lsu_if.cmd_ready, tbl[i].lr);
      check($sformatf("tbl%0d ifu_rsp_valid", i), ifu_if.rsp_valid, tbl[i].irv);
      check($sformatf("tbl%0d lsu_rsp_valid", i), lsu_if.rsp_valid, tbl[i].lrv);
      check($sformatf("tbl%0d itcm_rsp_ready", i), itcm_if.rsp_ready, tbl[i].rr);
      if (tbl[i].irv) check($sformatf("tbl%0d ifu_rdata", i), ifu_if.rsp_rdata, tbl[i].rdata);
      tick(1);
    end

    // Both requesters always valid: IFU for LIMIT cycles, then one LSU grant.
    for (int k = 0; k < 10; k++) begin
      drive(1, 16'h100 + 16'(k), 1, 16'h200 + 16'(k), 1, 64'h0, 8'h0, 1,
            (k > 0), 1, 1, 64'(k), 0);
      #1;
      check($sformatf("starve grant cycle %0d", k), {lsu_if.cmd_ready, ifu_if.cmd_ready},
            (k % 5 == 4) ? 2'b10 : 2'b01);
      tick(1);
    end
    drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'h0, 0);
    #1;
    tick(1);

    // LSU write, then IFU read whose response is held for three cycles.
    drive(0, 0, 1, 16'h50, 0, 64'h1122_3344_5566_7788, 8'hFF, 1, 0, 0, 1, 64'h0, 0);
    #1;
    check("wr cmd_read", itcm_if.cmd_read, 1'b0);
    check("wr cmd_wdata", itcm_if.cmd_wdata, 64'h1122_3344_5566_7788);
    check("wr cmd_wmask", itcm_if.cmd_wmask, 8'hFF);
    check("wr lsu_cmd_ready", lsu_if.cmd_ready, 1'b1);
    tick(1);
    drive(1, 16'h58, 0, 0, 1, 64'h0, 8'h0, 1, 1, 0, 1, 64'hA, 0);
    #1;
    check("rd ifu_cmd_ready", ifu_if.cmd_ready, 1'b1);
    check("rd cmd_wmask", itcm_if.cmd_wmask, 8'h00);
    check("wr lsu_rsp_valid", lsu_if.rsp_valid, 1'b1);
    check("wr ifu_rsp_valid", ifu_if.rsp_valid, 1'b0);
    check("wr itcm_rsp_ready", itcm_if.rsp_ready, 1'b1);
    tick(1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 1, 0, 1, 64'hB, 0);
      #1;
      check("held ifu_rsp_valid", ifu_if.rsp_valid, 1'b1);
      check("held itcm_rsp_ready", itcm_if.rsp_ready, 1'b0);
      check("held lsu_rsp_valid", lsu_if.rsp_valid, 1'b0);
      tick(1);
    end
    drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'hB, 0);
    #1;
    check("release itcm_rsp_ready", itcm_if.rsp_ready, 1'b1);
    check("release ifu_rdata", ifu_if.rsp_rdata, 64'hB);
    tick(1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic rv;
      rv = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      drive(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
            {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 3) != 0), rv,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, 1'($urandom));
      #1;
      tick(1);
    end

    // Drain, leave two IFU commands outstanding, then reset mid-flight.
    for (int i = 0; i < 8 && m_q.size() > 0; i++) begin
      drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'h0, 0);
      #1;
      tick(1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h60 + 16'(i), 0, 0, 1, 64'h0, 8'h0, 1, 0, 1, 1, 64'h0, 0);
      #1;
      tick(1);
    end
    rst = 1'b1;
    drive(1, 16'h70, 1, 16'h74, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'h0, 0);
    #1;
    check("midrst itcm_cmd_valid", itcm_if.cmd_valid, 1'b0);
    check("midrst ifu_rsp_valid", ifu_if.rsp_valid, 1'b0);
    check("midrst itcm_rsp_ready", itcm_if.rsp_ready, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 0, 1, 1, 64'h0, 0);
    #1;
    check("post-rst orphan clear", orphan, 1'b0);
    tick(1);
    drive(0, 0, 0, 0, 1, 64'h0, 8'h0, 1, 1, 1, 1, 64'h5, 0);
    #1;
    check("orphan ifu_rsp_valid", ifu_if.rsp_valid, 1'b0);
    check("orphan lsu_rsp_valid", lsu_if.rsp_valid, 1'b0);
    check("orphan itcm_rsp_ready", itcm_if.rsp_ready, 1'b1);
    tick(1);
    drive(1, 16'h80, 0, 0, 1, 64'h0, 8'h0, 1, 0, 1, 1, 64'h0, 0);
    #1;
    check("orphan flag set", orphan, 1'b1);
    check("post-rst fifo accepts", itcm_if.cmd_valid, 1'b1);
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_itcm_icb_arbt.md
Name: e203_itcm_icb_arbt

Overview:
Two-requester ICB arbiter that shares the single ITCM ICB port between the IFU fetch path (read-only) and the LSU data path (read/write). It sits between the IFU's fetch-to-ICB bridge and the LSU on one side, and the ITCM controller on the other. Commands are single-beat. A small outstanding-ID FIFO routes each ITCM response back to the requester that issued the matching command, in order.

Parameters:
AW, 16 (`E203_ITCM_ADDR_WIDTH), ITCM byte-address width.
DW, 64 (`E203_ITCM_DATA_WIDTH), ITCM data width.
OUTS_DEPTH, 2, maximum outstanding commands not yet responded; 1..4.
STARVE_LIMIT, 4, LSU wait cycles before it takes priority (fixed-priority mode only); 1..15.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ifu_cmd_valid  in  1  IFU fetch request
ifu_cmd_ready  out  1  IFU command accepted
ifu_cmd_addr  in  AW  IFU fetch address
ifu_rsp_valid  out  1  IFU response valid
ifu_rsp_ready  in  1  IFU can take response
ifu_rsp_err  out  1  IFU response error
ifu_rsp_rdata  out  DW  IFU fetch data
lsu_cmd_valid  in  1  LSU request
lsu_cmd_ready  out  1  LSU command accepted
lsu_cmd_addr  in  AW  LSU address
lsu_cmd_read  in  1  1 = read, 0 = write
lsu_cmd_wdata  in  DW  LSU write data
lsu_cmd_wmask  in  DW/8  LSU byte mask
lsu_rsp_valid  out  1  LSU response valid
lsu_rsp_ready  in  1  LSU can take response
lsu_rsp_err  out  1  LSU response error
lsu_rsp_rdata  out  DW  LSU read data
itcm_cmd_valid  out  1  ITCM command valid
itcm_cmd_ready  in  1  ITCM accepts command
itcm_cmd_addr  out  AW  ITCM address
itcm_cmd_read  out  1  ITCM read/write
itcm_cmd_wdata  out  DW  ITCM write data
itcm_cmd_wmask  out  DW/8  ITCM byte mask
itcm_rsp_valid  in  1  ITCM response valid
itcm_rsp_ready  out  1  arbiter accepts ITCM response
itcm_rsp_err  in  1  ITCM response error
itcm_rsp_rdata  in  DW  ITCM read data

Behaviour:
- Clock is clk. Reset is rst: one clock domain, asynchronous assertion, active-high.
- Reset state:
  - outstanding FIFO empty
  - starvation counter 0
  - round-robin pointer selects IFU
  - all *_valid and *_ready outputs 0 while rst is asserted; data outputs don't-care.
- Grant is combinational each cycle. There is no lock, because commands are single-beat.
- Fixed priority: IFU wins unless starve_cnt == STARVE_LIMIT, in which case the LSU wins.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) in any cycle where lsu_cmd_valid=1 and the LSU is not handshaken;
  - clears on an LSU command handshake, or when lsu_cmd_valid=0.
- itcm_cmd_valid = (ifu_cmd_valid | lsu_cmd_valid) & ~fifo_full.
- The command mux selects the granted requester. For an IFU command: read=1, wdata=0, wmask=0.
- Granted cmd_ready = itcm_cmd_ready & ~fifo_full. The loser's cmd_ready is 0.
- A full FIFO blocks a push even when a pop happens in the same cycle. This keeps the ready path free of rsp_ready.
- On each itcm_cmd handshake, push the source ID (0 = IFU, 1 = LSU).
- Response routing uses the FIFO head ID:
  - head=0: ifu_rsp_valid = itcm_rsp_valid, itcm_rsp_ready = ifu_rsp_ready;
  - head=1: same for the LSU port.
  - rdata and err are passed straight through to both ports; only the valid signals are gated.
- On each itcm_rsp handshake, pop the FIFO.
- Latency: zero added cycles in either direction.
- Backpressure on one requester's response stalls all later responses (in-order).
- If itcm_rsp_valid arrives with the FIFO empty:
  - it is a protocol violation;
  - itcm_rsp_ready=1 (the response is dropped), and both rsp_valid outputs stay 0;
  - the sticky simulation-only flag arbt_orphan_rsp is set.
- Reset asserted mid-operation clears the FIFO. Any in-flight response after reset is treated as orphaned.

Optional Feature:
E203_ITCM_ARBT_RR_EN
- Defined: round-robin arbitration.
  - Pointer flips to the other requester after every command handshake.
  - The pointer's requester wins when both are valid.
  - The starvation counter is not instantiated.
- Undefined: fixed IFU priority with the STARVE_LIMIT override described above.

Decomposition:
- Shared defines in e203_defines.v: `E203_ITCM_ARBT_OUTS_DEPTH, `E203_ITCM_ARBT_STARVE_LIMIT, source-ID encodings `E203_ITCM_ARBT_ID_IFU=1'b0 and `E203_ITCM_ARBT_ID_LSU=1'b1.
- One sub-module: e203_itcm_arbt_outs_fifo. It is a 1-bit-wide FIFO of depth OUTS_DEPTH with push/pop/full/empty/head.
  - Pointers wrap modulo OUTS_DEPTH.
  - Simultaneous push and pop when not empty: count is unchanged.

Test Plan:
1. IFU only, addr 0x0010, itcm_cmd_ready=1, rsp rdata 0xDEAD_BEEF_0000_0001 one cycle later. Required: itcm_cmd_addr=0x0010 with read=1; ifu_rsp_valid in the same cycle as itcm_rsp_valid; lsu_rsp_valid stays 0.
2. Both valid continuously, fixed mode, STARVE_LIMIT=4. Required: IFU is granted for 4 cycles, LSU is granted on cycle 5, and the pattern repeats.
3. OUTS_DEPTH=2, two IFU commands issued, ITCM responses withheld. Required: third command sees ifu_cmd_ready=0 and itcm_cmd_valid=0; after one response, ready returns the next cycle.
4. LSU write (wmask 0xFF) followed by an IFU read, with ifu_rsp_ready=0 for 3 cycles. Required: LSU response delivered first; IFU response held until ifu_rsp_ready=1 with itcm_rsp_ready tracking it.
5. RR_EN defined, both valid continuously. Required: grants alternate IFU, LSU, IFU, LSU.
6. rst pulsed with 2 commands outstanding. Required: FIFO empty, a subsequent itcm_rsp_valid is dropped with no rsp_valid output, and arbt_orphan_rsp is set.
